// File: rtl/fp_pkg.sv
// Shared FP adder definitions: rounding modes, GRS mantissa layout, operand classes.
package fp_pkg;

  localparam int unsigned MANT_W    = 28;
  localparam int unsigned SHIFT_SAT = 27;
  localparam int unsigned EXP_BIAS  = 127;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // [27] carry headroom, [26:3] significand with hidden bit, [2] G, [1] R, [0] S
  typedef logic [MANT_W-1:0] grs_mant_t;

  typedef enum logic [2:0] {ZERO, SUB, NORM, INF, NAN} fp_class_e;

endpackage

// File: rtl/fp_unpack.sv
// Splits a single-precision operand into sign, effective exponent, 24-bit significand and class.
module fp_unpack
  import fp_pkg::*;
(
  input  logic [31:0] op_i,
  output logic        sign_o,
  output logic [7:0]  exp_eff_o,
  output logic [23:0] sig24_o,
  output fp_class_e   cls_o
);

  logic [7:0]  e;
  logic [22:0] f;

  always_comb begin
    e         = op_i[30:23];
    f         = op_i[22:0];
    sign_o    = op_i[31];
    exp_eff_o = (e == 8'd0) ? 8'd1 : e;
    sig24_o   = {(e != 8'd0), f};
    if (e == 8'd0)
      cls_o = (f == 23'd0) ? ZERO : SUB;
    else if (e == 8'hFF)
      cls_o = (f == 23'd0) ? INF : NAN;
    else
      cls_o = NORM;
  end

endmodule

// File: rtl/fp_add_align.sv
// FP adder front end: stage 1 unpacks, classifies and orders operands; stage 2 aligns the smaller mantissa.
module fp_add_align
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        op_sub,
  input  logic [2:0]  rm_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        sign_out,
  output logic        eff_sub,
  output logic [7:0]  exp_out,
  output grs_mant_t   mant_big,
  output grs_mant_t   mant_small,
  output logic [2:0]  rm_out,
  output logic        special,
  output logic [31:0] special_res,
  output logic        invalid
);

  localparam logic [7:0] SAT_D = 8'(SHIFT_SAT);

  typedef struct packed {
    logic        sign;
    logic        eff;
    logic [7:0]  exp_big;
    logic [7:0]  exp_small;
    logic [23:0] sig_big;
    logic [23:0] sig_small;
    logic [2:0]  rm;
    logic        special;
    logic [31:0] res;
    logic        invalid;
  } s1_t;

  typedef struct packed {
    logic        sign;
    logic        eff;
    logic [7:0]  exp;
    grs_mant_t   mb;
    grs_mant_t   ms;
    logic [2:0]  rm;
    logic        special;
    logic [31:0] res;
    logic        invalid;
  } s2_t;

  logic        a_sign, b_sign, b_sign_eff, eff, a_ge, tie;
  logic [7:0]  a_exp, b_exp, d;
  logic [23:0] a_sig, b_sig;
  fp_class_e   a_cls, b_cls;
  logic [54:0] wide;

  logic init_q, s1_valid_q, s2_valid_q, adv1, adv2, accept;
  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;

  fp_unpack u_unpack_a (.op_i(op_a), .sign_o(a_sign), .exp_eff_o(a_exp), .sig24_o(a_sig), .cls_o(a_cls));
  fp_unpack u_unpack_b (.op_i(op_b), .sign_o(b_sign), .exp_eff_o(b_exp), .sig24_o(b_sig), .cls_o(b_cls));

  assign adv2     = ~s2_valid_q | out_ready;
  assign adv1     = ~s1_valid_q | adv2;
  assign in_ready = adv1 & init_q;
  assign accept   = in_valid & in_ready;

  always_comb begin
    s1_d       = '0;
    b_sign_eff = b_sign ^ op_sub;
    eff        = a_sign ^ b_sign_eff;
    a_ge       = {a_exp, a_sig} >= {b_exp, b_sig};
    tie        = {a_exp, a_sig} == {b_exp, b_sig};
    s1_d.rm    = rm_in;
    s1_d.eff   = eff;
    // Specials leave exponents/significands zero so stage 2 naturally emits zero mantissas.
    if (a_cls == NAN || b_cls == NAN || (a_cls == INF && b_cls == INF && eff)) begin
      s1_d.special = 1'b1;
      s1_d.res     = QNAN;
      s1_d.invalid = 1'b1;
    end else if (a_cls == INF) begin
      s1_d.special = 1'b1;
      s1_d.sign    = a_sign;
      s1_d.res     = {a_sign, 8'hFF, 23'd0};
    end else if (b_cls == INF) begin
      s1_d.special = 1'b1;
      s1_d.sign    = b_sign_eff;
      s1_d.res     = {b_sign_eff, 8'hFF, 23'd0};
    end else begin
      s1_d.sign      = (tie && eff) ? (rm_in == RM_RDN) : (a_ge ? a_sign : b_sign_eff);
      s1_d.exp_big   = a_ge ? a_exp : b_exp;
      s1_d.exp_small = a_ge ? b_exp : a_exp;
      s1_d.sig_big   = a_ge ? a_sig : b_sig;
      s1_d.sig_small = a_ge ? b_sig : a_sig;
    end
  end

  always_comb begin
    s2_d         = '0;
    d            = s1_q.exp_big - s1_q.exp_small;
    wide         = {1'b0, s1_q.sig_small, 3'b000, 27'd0} >> d;
    s2_d.sign    = s1_q.sign;
    s2_d.eff     = s1_q.eff;
    s2_d.exp     = s1_q.exp_big;
    s2_d.mb      = {1'b0, s1_q.sig_big, 3'b000};
    s2_d.rm      = s1_q.rm;
    s2_d.special = s1_q.special;
    s2_d.res     = s1_q.res;
    s2_d.invalid = s1_q.invalid;
    if (d >= SAT_D)
      s2_d.ms = {27'd0, |s1_q.sig_small};
    else
      s2_d.ms = {wide[54:28], wide[27] | (|wide[26:0])};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      init_q     <= 1'b0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      init_q <= 1'b1;
      if (adv1) begin
        s1_valid_q <= accept;
        if (accept) s1_q <= s1_d;
      end
      if (adv2) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) s2_q <= s2_d;
      end
    end
  end

  assign out_valid   = s2_valid_q;
  assign sign_out    = s2_q.sign;
  assign eff_sub     = s2_q.eff;
  assign exp_out     = s2_q.exp;
  assign mant_big    = s2_q.mb;
  assign mant_small  = s2_q.ms;
  assign rm_out      = s2_q.rm;
  assign special     = s2_q.special;
  assign special_res = s2_q.res;
  assign invalid     = s2_q.invalid;

endmodule

// File: tb/tb_fp_add_align.sv
// Scoreboard bench for fp_add_align: directed cases, backpressure, reset flush and random traffic.
module tb_fp_add_align;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] op_a = '0, op_b = '0;
  logic        op_sub = 1'b0;
  logic [2:0]  rm_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        sign_out, eff_sub, special, invalid;
  logic [7:0]  exp_out;
  logic [27:0] mant_big, mant_small;
  logic [2:0]  rm_out;
  logic [31:0] special_res;

  fp_add_align dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_sub(op_sub), .rm_in(rm_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .sign_out(sign_out), .eff_sub(eff_sub), .exp_out(exp_out),
    .mant_big(mant_big), .mant_small(mant_small), .rm_out(rm_out),
    .special(special), .special_res(special_res), .invalid(invalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sign, eff;
    logic [7:0]  exp;
    logic [27:0] mb, ms;
    logic [2:0]  rm;
    logic        spc;
    logic [31:0] res;
    logic        inv;
    int          cyc;
    bit          chk_lat;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  bit   rnd_ready = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic sub, input logic [2:0] rm);
    exp_t   e;
    int     ea, eb, xa, xb, d;
    longint sa, sb, ma, mbv, ss, q, r;
    logic   sgna, sgnb;
    bit     nana, nanb, infa, infb, es, abig;
    e = '{default: 0};
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    sgna = a[31];
    sgnb = b[31] ^ sub;
    es = (sgna != sgnb);
    nana = (ea == 255) && (a[22:0] != 0);
    nanb = (eb == 255) && (b[22:0] != 0);
    infa = (ea == 255) && (a[22:0] == 0);
    infb = (eb == 255) && (b[22:0] == 0);
    e.rm = rm;
    if (nana || nanb || (infa && infb && es)) begin
      e.spc = 1; e.res = 32'h7FC0_0000; e.inv = 1;
      return e;
    end
    if (infa || infb) begin
      e.spc = 1; e.res = {(infa ? sgna : sgnb), 8'hFF, 23'd0};
      return e;
    end
    xa = (ea == 0) ? 1 : ea;
    xb = (eb == 0) ? 1 : eb;
    sa = longint'(a[22:0]) + ((ea == 0) ? 0 : 64'd8388608);
    sb = longint'(b[22:0]) + ((eb == 0) ? 0 : 64'd8388608);
    ma  = longint'(xa) * 16777216 + sa;
    mbv = longint'(xb) * 16777216 + sb;
    abig = (ma >= mbv);
    e.eff  = es;
    e.sign = (ma == mbv && es) ? (rm == 3'd2) : (abig ? sgna : sgnb);
    e.exp  = 8'(abig ? xa : xb);
    e.mb   = 28'((abig ? sa : sb) * 8);
    d  = abig ? xa - xb : xb - xa;
    ss = abig ? sb : sa;
    if (d >= 27) begin
      e.ms = (ss != 0) ? 28'd1 : 28'd0;
    end else begin
      q = (ss * 8) / (64'd1 << d);
      r = (ss * 8) % (64'd1 << d);
      e.ms = 28'(q | ((r != 0) ? 64'd1 : 64'd0));
    end
    return e;
  endfunction

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub,
                      input logic [2:0] rm, input bit lat);
    exp_t e;
    int   waits = 0;
    op_a = a; op_b = b; op_sub = sub; rm_in = rm; in_valid = 1'b1;
    if (rnd_ready) out_ready = ($urandom % 4) != 0;
    #1;
    while (!in_ready) begin
      if (waits == 200) begin
        miscompares++;
        $display("FAIL accept_timeout in_ready stayed 0, required 1 within 200 cycles");
        in_valid = 1'b0;
        return;
      end
      waits++;
      @(negedge clk);
      if (rnd_ready) out_ready = ($urandom % 4) != 0;
      #1;
    end
    e = model(a, b, sub, rm);
    e.cyc = cyc;
    e.chk_lat = lat;
    sbq.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      if (rnd_ready) out_ready = ($urandom % 4) != 0;
    end
  endtask

  task automatic check1(input string nm, input logic [127:0] got, input logic [127:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got %h required %h", nm, got, want);
    end
  endtask

  function automatic logic [31:0] rnd_op(input int near);
    int sel, e;
    logic [22:0] f;
    sel = int'($urandom % 16);
    if (sel == 0) e = 0;
    else if (sel == 1) e = 255;
    else if (sel < 8 && near >= 0) begin
      e = near + int'($urandom_range(0, 60)) - 30;
      if (e < 0) e = 0;
      if (e > 255) e = 255;
    end else e = int'($urandom_range(1, 254));
    f = ($urandom % 6 == 0) ? 23'd0 : 23'($urandom);
    return {1'($urandom), 8'(e), f};
  endfunction

  logic [102:0] snap_prev;
  bit           stall_prev = 0;

  function automatic logic [102:0] snap();
    return {sign_out, eff_sub, exp_out, mant_big, mant_small, rm_out, special, special_res, invalid};
  endfunction

  always begin
    exp_t e;
    bit   bad;
    @(negedge clk);
    #2;
    if (rst) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        vectors++;
        if (!out_valid || snap() !== snap_prev) begin
          miscompares++;
          $display("FAIL hold_stable got valid=%0d data=%h required valid=1 data=%h",
                   out_valid, snap(), snap_prev);
        end
      end
      if (out_valid && out_ready) begin
        vectors++;
        if (sbq.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_out got out_valid=1 required no output pending");
        end else begin
          e = sbq.pop_front();
          if (e.spc)
            bad = !(special === 1'b1 && special_res === e.res && invalid === e.inv &&
                    mant_big === 28'd0 && mant_small === 28'd0 && rm_out === e.rm);
          else
            bad = !(special === 1'b0 && special_res === 32'd0 && invalid === 1'b0 &&
                    sign_out === e.sign && eff_sub === e.eff && exp_out === e.exp &&
                    mant_big === e.mb && mant_small === e.ms && rm_out === e.rm);
          if (bad) begin
            miscompares++;
            $display("FAIL result got s=%0d eff=%0d exp=%h mb=%h ms=%h rm=%0d spc=%0d res=%h inv=%0d required s=%0d eff=%0d exp=%h mb=%h ms=%h rm=%0d spc=%0d res=%h inv=%0d",
                     sign_out, eff_sub, exp_out, mant_big, mant_small, rm_out, special, special_res, invalid,
                     e.sign, e.eff, e.exp, e.mb, e.ms, e.rm, e.spc, e.res, e.inv);
          end
          if (e.chk_lat) check1("latency", 128'(cyc - e.cyc), 128'd2);
        end
      end
      stall_prev = out_valid && !out_ready;
      snap_prev  = snap();
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout simulation still running, required completion");
    $fatal(1);
  end

  initial begin
    int drain;
    logic [31:0] a, b;
    repeat (2) @(negedge clk);
    #1;
    check1("reset_out_valid", 128'(out_valid), 128'd0);
    check1("reset_in_ready", 128'(in_ready), 128'd0);
    check1("reset_outputs", 128'(snap()), 128'd0);
    rst = 1'b0;
    check1("in_ready_before_edge", 128'(in_ready), 128'd0);
    @(negedge clk);
    #1;
    check1("in_ready_after_release", 128'(in_ready), 128'd1);
    @(negedge clk);

    out_ready = 1'b1;
    send(32'h3F80_0000, 32'h3F80_0000, 1'b0, 3'd0, 1'b1);
    idle(4);
    send(32'h3FC0_0000, 32'h4040_0000, 1'b1, 3'd0, 1'b0);
    send(32'h3F80_0000, 32'h3080_0000, 1'b0, 3'd1, 1'b0);
    send(32'h0000_0001, 32'h0000_0001, 1'b0, 3'd0, 1'b0);
    send(32'h7F80_0000, 32'h7F80_0000, 1'b1, 3'd0, 1'b0);
    send(32'h3F80_0000, 32'h3F80_0000, 1'b1, 3'd2, 1'b0);
    send(32'h3F80_0000, 32'h3F80_0000, 1'b1, 3'd0, 1'b0);
    send(32'h7FC0_1234, 32'h3F80_0000, 1'b0, 3'd4, 1'b0);
    send(32'h4000_0000, 32'hFF80_0000, 1'b0, 3'd3, 1'b0);
    send(32'h0000_0000, 32'h8000_0000, 1'b0, 3'd0, 1'b0);
    send(32'h4B00_0001, 32'h3F00_0001, 1'b0, 3'd0, 1'b0);
    idle(4);

    out_ready = 1'b0;
    send(32'h4100_0000, 32'h3F80_0000, 1'b0, 3'd0, 1'b0);
    send(32'h4120_0000, 32'hC080_0000, 1'b0, 3'd1, 1'b0);
    op_a = 32'h4130_0000; op_b = 32'h3F00_0000; op_sub = 1'b1; rm_in = 3'd2; in_valid = 1'b1;
    #1;
    check1("in_ready_full", 128'(in_ready), 128'd0);
    @(negedge clk);
    out_ready = 1'b1;
    send(32'h4130_0000, 32'h3F00_0000, 1'b1, 3'd2, 1'b0);
    send(32'h0040_0000, 32'h0080_0000, 1'b1, 3'd3, 1'b0);
    idle(4);

    out_ready = 1'b0;
    send(32'h4200_0000, 32'h4100_0000, 1'b0, 3'd0, 1'b0);
    send(32'h4300_0000, 32'h4180_0000, 1'b1, 3'd0, 1'b0);
    idle(1);
    rst = 1'b1;
    sbq.delete();
    @(negedge clk);
    #1;
    check1("flush_out_valid", 128'(out_valid), 128'd0);
    check1("flush_outputs", 128'(snap()), 128'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    idle(6);

    rnd_ready = 1;
    for (int i = 0; i < 300; i++) begin
      a = rnd_op(-1);
      b = rnd_op(int'(a[30:23]));
      send(a, b, 1'($urandom), 3'($urandom % 5), 1'b0);
      if ($urandom % 5 == 0) idle(int'($urandom_range(1, 3)));
    end
    rnd_ready = 0;
    out_ready = 1'b1;
    drain = 0;
    while (sbq.size() != 0 && drain < 100) begin
      @(negedge clk);
      drain++;
    end
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout got %0d results pending, required 0", sbq.size());
    end
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fp_add_align.md
Name: fp_add_align

Overview:
- Front end of the FP adder datapath; the producer side of fp_normalize_round.
- Accepts two IEEE-754 single-precision operands plus an add/sub op and a rounding mode.
- Unpacks and classifies both operands, orders them by magnitude, and right-aligns the smaller mantissa with guard/round/sticky bits.
- Output mantissas use the same 28-bit GRS layout that fp_normalize_round consumes. Two-stage pipeline with valid/ready handshake on both sides.

Parameters:
- MANT_W, 28, aligned mantissa width: [27]=carry headroom, [26:3]=24-bit significand with hidden bit, [2]=G, [1]=R, [0]=S
- SHIFT_SAT, 27, alignment distance at or above which the small operand collapses to sticky only

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- op_a  in  32  IEEE-754 operand A
- op_b  in  32  IEEE-754 operand B
- op_sub  in  1  1 = A−B, 0 = A+B
- rm_in  in  3  rounding mode (000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM)
- out_valid  out  1  aligned result valid
- out_ready  in  1  downstream accepts
- sign_out  out  1  sign of larger-magnitude operand (after the op_sub flip of B)
- eff_sub  out  1  effective subtraction (signs differ after the flip)
- exp_out  out  8  exponent of larger operand; subnormal/zero use 1
- mant_big  out  28  larger significand, MANT_W layout, GRS=000
- mant_small  out  28  smaller significand shifted right by exponent difference, sticky-collapsed
- rm_out  out  3  rm_in delayed with the data
- special  out  1  result fully determined by special-case logic
- special_res  out  32  packed result when special=1, else 0
- invalid  out  1  invalid-operation flag (NaN source or Inf−Inf)

Behaviour:
- Reset values: all outputs 0 except in_ready, which is 1 one cycle after rst is released; both stage valid bits clear.
- rst mid-operation discards in-flight data; no out_valid may be issued for pre-reset inputs.
- Handshake:
  - Transfer occurs when valid && ready.
  - adv2 = ~s2_valid | out_ready; adv1 = ~s1_valid | adv2; in_ready = adv1.
  - Outputs hold stable while out_valid && !out_ready.
  - Latency is 2 cycles from accept to out_valid with no stall; throughput is 1 per cycle.
  - No combinational path from out_ready to in_ready other than the adv chain above.
- Stage 1 (unpack/classify/order):
  - b_sign_eff = op_b[31] ^ op_sub.
  - Per operand: zero (e=0, f=0), subnormal (e=0, f≠0, hidden bit 0, effective exponent 1), normal (hidden bit 1), Inf (e=FF, f=0), NaN (e=FF, f≠0).
  - Magnitude compare on {exp_eff, sig24}. The larger goes to the big slot; on a tie A is big.
  - sign_out = big sign. On an exact tie with eff_sub, sign_out = (rm==RDN).
  - Specials:
    - Any NaN → special_res 7FC00000, invalid=1.
    - Inf−Inf (eff_sub) → 7FC00000, invalid=1.
    - A single Inf → that Inf with its effective sign, invalid=0.
- Stage 2 (align):
  - d = exp_big_eff − exp_small_eff (8-bit, never negative).
  - mant_small = {0, sig_small, 000} >> d. Bit [0] = OR of the shifted result's bit 0 and every bit shifted out.
  - d ≥ SHIFT_SAT → mant_small = {27'b0, |sig_small}.
  - d = 0 → no shift.
  - Zero operand → its significand is 0, so mant_small = 0.
- exp_out never exceeds FE for non-special results. Special-case mantissa outputs are don't-care and are driven 0.

Decomposition:
- Shared package fp_pkg:
  - rounding-mode constants RM_RNE..RM_RMM
  - the 28-bit GRS mantissa typedef
  - the class enum {ZERO, SUB, NORM, INF, NAN}
  - QNAN constant 7FC00000
  - EXP_BIAS = 127
- fp_normalize_round moves its rm encodings into the same package.
- One sub-module: fp_unpack (combinational, one instance per operand). Outputs sign, exp_eff, sig24 and class.

Test Plan:
- 3F800000 + 3F800000 → exp_out 7F, mant_big = mant_small = 4000000, eff_sub 0, sign 0, out_valid exactly 2 cycles after accept.
- 3FC00000 − 40400000 (1.5−3.0) → sign_out 1, eff_sub 1, exp_out 80, mant_big 6000000, mant_small 3000000.
- 3F800000 + 30800000 (d=30) → mant_small 0000001 (sticky only), mant_big 4000000, exp_out 7F.
- 00000001 + 00000001 → exp_out 01, mant_big = mant_small = 0000008, special 0.
- 7F800000 − 7F800000 → special 1, special_res 7FC00000, invalid 1.
- Backpressure:
  - Stimulus: stream 4 pairs, hold out_ready=0 for 3 cycles.
  - out_valid and data stay constant; in_ready drops after 2 accepts; all 4 results emerge in order.
  - Assert rst during the stall → out_valid 0 next cycle and no stale outputs afterwards.
